// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-side pipeline blocks.
package mips_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam int          WORD_BYTES = 4;

endpackage : mips_pkg

// File: rtl/instr_mem.sv
// Word-addressed instruction store: one synchronous write port for the boot
// loader, one asynchronous read port for the single-cycle fetch path.
module instr_mem #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   // Contents are deliberately not reset; a fresh load overwrites them.
   logic [31:0] mem [DEPTH];

   // Loader write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Zero-latency read; out-of-range indices are masked by the caller.
   assign rdata = mem[raddr];

endmodule : instr_mem

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: boot-time program load, combinational fetch at the
// current PC, PC-register hold gating and sticky fetch-fault detection.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        core_hold,
   output logic        running,
   output logic        fault,
   output logic [31:0] fetch_count
);

   fetch_state_t      state_reg;
   logic [ADDR_W-1:0] load_addr_reg;
   logic              fault_reg;
   logic [31:0]       fetch_count_reg;

   logic              load_fire;
   logic              load_full;
   logic              fetch_legal;
   logic [31:0]       mem_rdata;

   assign load_fire = (state_reg == LOAD) && ld_valid;
   assign load_full = (load_addr_reg == ADDR_W'(DEPTH - 1));

   // Full 30-bit word-index compare so high PC bits can never alias into memory.
   assign fetch_legal = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < 32'(DEPTH));

   instr_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (load_fire),
      .waddr (load_addr_reg),
      .wdata (ld_data),
      .raddr (pc[ADDR_W+1:2]),
      .rdata (mem_rdata)
   );

   // Load / run / fault sequencing with load counter, fault flag and fetch counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= LOAD;
         load_addr_reg   <= '0;
         fault_reg       <= 1'b0;
         fetch_count_reg <= '0;
      end else begin
         case (state_reg)
            LOAD: begin
               if (ld_valid) begin
                  load_addr_reg <= load_addr_reg + ADDR_W'(1);
                  // Memory full forces RUN so no word is ever written past the end.
                  if (ld_last || load_full) begin
                     state_reg <= RUN;
                  end
               end
            end
            RUN: begin
               if (fetch_legal) begin
                  if (fetch_count_reg != 32'hFFFF_FFFF) begin
                     fetch_count_reg <= fetch_count_reg + 32'd1;
                  end
               end else begin
                  fault_reg <= 1'b1;
                  state_reg <= FAULT;
               end
            end
            FAULT: begin
               // Halted until reset.
            end
            default: begin
               fault_reg <= 1'b1;
               state_reg <= FAULT;
            end
         endcase
      end
   end

   // Handshake and hold outputs decode straight from the state register so the
   // PC register leaves reset in the very first RUN cycle.
   assign ld_ready    = (state_reg == LOAD);
   assign running     = (state_reg == RUN);
   assign core_hold   = (state_reg != RUN);
   assign fault       = fault_reg;
   assign fetch_count = fetch_count_reg;
   assign instr       = (running && fetch_legal) ? mem_rdata : NOP_INSTR;
   assign pc_plus4    = pc + 32'(WORD_BYTES);

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit against a program-level model.
module tb_instr_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic        core_hold;
   logic        running;
   logic        fault;
   logic [31:0] fetch_count;

   instr_fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .pc          (pc),
      .instr       (instr),
      .pc_plus4    (pc_plus4),
      .core_hold   (core_hold),
      .running     (running),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        ld_ready;
      logic        core_hold;
      logic        running;
      logic        fault;
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic [31:0] fetch_count;
   } exp_t;

   exp_t exp_q[$];
   event push_ev;
   int   checks = 0;
   int   passed = 0;
   int   txn    = 0;

   // Reference model: the program as a list of words plus a few facts about it.
   logic [31:0] prog [DEPTH];
   int          n_loaded;
   bit          loaded;
   bit          halted;
   logic [31:0] count;

   function automatic bit legal_pc(logic [31:0] p);
      return (p % 4 == 0) && (p / 4 < DEPTH);
   endfunction

   function automatic void model_reset();
      loaded   = 1'b0;
      halted   = 1'b0;
      n_loaded = 0;
      count    = 32'd0;
   endfunction

   task automatic push_expect(input string name);
      exp_t e;
      bit   exec;
      exec          = loaded && !halted;
      e.name        = name;
      e.ld_ready    = !loaded;
      e.running     = exec;
      e.core_hold   = !exec;
      e.fault       = halted;
      e.instr       = (exec && legal_pc(pc)) ? prog[pc / 4] : 32'h0;
      e.pc_plus4    = pc + 32'd4;
      e.fetch_count = count;
      exp_q.push_back(e);
      -> push_ev;
   endtask

   // What the coming clock edge does to the program-level state.
   function automatic void model_step();
      if (!loaded) begin
         if (ld_valid) begin
            prog[n_loaded] = ld_data;
            n_loaded++;
            if (ld_last || n_loaded == DEPTH) loaded = 1'b1;
         end
      end else if (!halted) begin
         if (legal_pc(pc)) begin
            if (count != 32'hFFFF_FFFF) count = count + 32'd1;
         end else begin
            halted = 1'b1;
         end
      end
   endfunction

   function automatic void chk(string n, string f, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s.%s got=%h want=%h", n, f, act, req);
   endfunction

   // Monitor: compares DUT outputs against each queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(push_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "ld_ready",    32'(ld_ready),  32'(e.ld_ready));
            chk(e.name, "core_hold",   32'(core_hold), 32'(e.core_hold));
            chk(e.name, "running",     32'(running),   32'(e.running));
            chk(e.name, "fault",       32'(fault),     32'(e.fault));
            chk(e.name, "instr",       instr,          e.instr);
            chk(e.name, "pc_plus4",    pc_plus4,       e.pc_plus4);
            chk(e.name, "fetch_count", fetch_count,    e.fetch_count);
            txn++;
            $display("txn %0d %s pc=%h instr=%h run=%0b flt=%0b cnt=%0d",
                     txn, e.name, pc, instr, running, fault, fetch_count);
         end
      end
   end

   task automatic cyc(input bit v, input logic [31:0] d, input bit l,
                      input logic [31:0] p, input string name);
      @(negedge clk);
      ld_valid = v;
      ld_data  = d;
      ld_last  = l;
      pc       = p;
      #1;
      push_expect(name);
      model_step();
   endtask

   task automatic sync_reset(input string name);
      @(negedge clk);
      ld_valid = 1'b0;
      pc       = 32'h0;
      reset    = 1'b1;
      model_reset();
      #1;
      push_expect(name);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Reset raised between edges; outputs must react before any clock.
   task automatic async_reset(input string name);
      @(negedge clk);
      #2;
      ld_valid = 1'b0;
      reset    = 1'b1;
      model_reset();
      #1;
      push_expect(name);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rand_load(input int n);
      for (int k = 0; k < n; k++) begin
         int gaps;
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++)
            cyc(1'b0, $urandom, 1'($urandom), 32'h0, "ld_gap");
         cyc(1'b1, $urandom, (k == n - 1) ? 1'b1 : 1'b0, 32'h0, "ld_word");
      end
   endtask

   task automatic rand_run(input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] p;
         if ($urandom_range(0, 7) == 0) p = $urandom;
         else p = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
         cyc(1'($urandom), $urandom, 1'($urandom), p, "run_rand");
      end
   endtask

   initial begin
      reset    = 1'b1;
      ld_valid = 1'b0;
      ld_data  = 32'h0;
      ld_last  = 1'b0;
      pc       = 32'h0;
      model_reset();
      #1;
      push_expect("reset");
      @(negedge clk);
      reset = 1'b0;

      // Three-word program with a two-cycle loader stall before the last word.
      cyc(1'b1, 32'h2008_0005, 1'b0, 32'h0, "ld_w0");
      cyc(1'b1, 32'h2009_0003, 1'b0, 32'h0, "ld_w1");
      cyc(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, "ld_stall0");
      cyc(1'b0, 32'hCAFE_F00D, 1'b1, 32'h0, "ld_stall1");
      cyc(1'b1, 32'h0109_5020, 1'b1, 32'h0, "ld_w2_last");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "run_pc0");
      cyc(1'b0, 32'h0, 1'b0, 32'h4, "run_pc4");
      cyc(1'b0, 32'h0, 1'b0, 32'h8, "run_pc8");
      cyc(1'b0, 32'h0, 1'b0, 32'h6, "misaligned");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "fault_hold");
      cyc(1'b1, 32'h1234_5678, 1'b0, 32'h4, "fault_frozen");

      // Fill memory without ld_last: automatic transition, further words ignored.
      sync_reset("reset_fill");
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b1, $urandom, 1'b0, 32'h0, "fill_word");
      cyc(1'b1, 32'hFFFF_0000, 1'b1, 32'h0, "extra_word_ignored");
      cyc(1'b1, 32'hFFFF_1111, 1'b0, 32'hC, "run_pc_last");
      cyc(1'b0, 32'h0, 1'b0, 32'd4 * DEPTH, "out_of_range");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "oor_hold");

      // Asynchronous reset mid-run, then reload and run again.
      sync_reset("reset_async_prep");
      rand_load(DEPTH);
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "pre_async0");
      cyc(1'b0, 32'h0, 1'b0, 32'h4, "pre_async1");
      async_reset("async_reset");
      rand_load(2);
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "rerun0");
      cyc(1'b0, 32'h0, 1'b0, 32'h4, "rerun1");
      cyc(1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, "pc_top_wrap");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "top_fault_hold");

      // Randomized load lengths, stalls, mid-load resets and run traffic.
      for (int it = 0; it < 6; it++) begin
         sync_reset("reset_rand");
         if ($urandom_range(0, 2) == 0) begin
            rand_load(1);
            sync_reset("reset_midload");
         end
         rand_load($urandom_range(1, DEPTH));
         rand_run(12);
      end

      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Hard ceiling so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_instr_fetch_unit
